// File: rtl/control_unit_if.sv
// Control-unit to datapath bundle: instruction/status inputs and per-cycle strobes.
// master = control unit, slave = datapath.
interface control_unit_if;
  logic [31:0] IR;
  logic        CON_FF;
  logic        mem_ready;
  logic        stop;

  logic PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Write;
  logic MDRin, MDRout, IRin, Yin, CONin;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout;
  logic [3:0] alu_op;
  logic Run;

  modport master (
    input  IR, CON_FF, mem_ready, stop,
    output PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Write,
           MDRin, MDRout, IRin, Yin, CONin,
           Gra, Grb, Grc, Rin, Rout, BAout, Cout, alu_op, Run
  );

  modport slave (
    output IR, CON_FF, mem_ready, stop,
    input  PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Write,
           MDRin, MDRout, IRin, Yin, CONin,
           Gra, Grb, Grc, Rin, Rout, BAout, Cout, alu_op, Run
  );
endinterface

// File: rtl/control_unit.sv
// Hardwired Moore control unit: fetch T0-T2, opcode-dependent execute T3-T7.
// state | meaning
// RESET | held by reset, all outputs 0
// T0-T2 | fetch (T1 waits on mem_ready)
// T3-T7 | execute steps, decoded from IR[31:27]
// PAUSE | stopped at an instruction boundary until stop drops
// HALT  | halt executed, left only by reset
module control_unit (
  input  logic clock,
  input  logic reset,
  control_unit_if.master cu
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_PAUSE, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_REG, C_IMM, C_LDI, C_LD, C_ST, C_BRX, C_HALT, C_NOP
  } iclass_t;

  state_t      state, state_next;
  iclass_t     iclass;
  logic [3:0]  alu_sel;
  logic        t1_held;
  logic        last;
  logic [4:0]  opcode;
  wire         unused_ok = &{1'b0, cu.IR[26:0]};

  assign opcode = cu.IR[31:27];

  always_comb begin
    iclass  = C_NOP;
    alu_sel = 4'd0;
    case (opcode)
      5'b00011: iclass = C_REG;
      5'b00100: begin iclass = C_REG; alu_sel = 4'd1; end
      5'b01001: begin iclass = C_REG; alu_sel = 4'd2; end
      5'b01010: begin iclass = C_REG; alu_sel = 4'd3; end
      5'b01011: iclass = C_IMM;
      5'b01100: begin iclass = C_IMM; alu_sel = 4'd2; end
      5'b01101: begin iclass = C_IMM; alu_sel = 4'd3; end
      5'b00001: iclass = C_LDI;
      5'b00000: iclass = C_LD;
      5'b00010: iclass = C_ST;
      5'b10010: iclass = C_BRX;
      5'b11010: iclass = C_HALT;
      default:  iclass = C_NOP;
    endcase
  end

  // t1_held marks a repeated T1 cycle so PCin fires only once per fetch
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_RESET;
      t1_held <= 1'b0;
    end else begin
      state   <= state_next;
      t1_held <= (state == S_T1) && !cu.mem_ready;
    end
  end

  always_comb begin
    state_next = state;
    last       = 1'b0;
    cu.PCout = 1'b0; cu.MARin = 1'b0; cu.IncPC = 1'b0; cu.Zin = 1'b0;
    cu.Zlowout = 1'b0; cu.PCin = 1'b0; cu.Read = 1'b0; cu.Write = 1'b0;
    cu.MDRin = 1'b0; cu.MDRout = 1'b0; cu.IRin = 1'b0; cu.Yin = 1'b0;
    cu.CONin = 1'b0; cu.Gra = 1'b0; cu.Grb = 1'b0; cu.Grc = 1'b0;
    cu.Rin = 1'b0; cu.Rout = 1'b0; cu.BAout = 1'b0; cu.Cout = 1'b0;
    cu.alu_op = 4'd0;
    cu.Run = 1'b1;

    case (state)
      S_RESET: begin
        cu.Run     = 1'b0;
        state_next = S_T0;
      end
      S_T0: begin
        cu.PCout = 1'b1; cu.MARin = 1'b1; cu.IncPC = 1'b1; cu.Zin = 1'b1;
        state_next = S_T1;
      end
      S_T1: begin
        cu.Zlowout = 1'b1; cu.PCin = !t1_held; cu.Read = 1'b1; cu.MDRin = 1'b1;
        if (cu.mem_ready) state_next = S_T2;
      end
      S_T2: begin
        cu.MDRout = 1'b1; cu.IRin = 1'b1;
        state_next = S_T3;
      end
      S_T3: begin
        state_next = S_T4;
        case (iclass)
          C_REG, C_IMM:       begin cu.Grb = 1'b1; cu.Rout = 1'b1; cu.Yin = 1'b1; end
          C_LDI, C_LD, C_ST:  begin cu.Grb = 1'b1; cu.BAout = 1'b1; cu.Yin = 1'b1; end
          C_BRX:              begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.CONin = 1'b1; end
          C_HALT:             state_next = S_HALT;
          default:            last = 1'b1;
        endcase
      end
      S_T4: begin
        state_next = S_T5;
        case (iclass)
          C_REG: begin cu.Grc = 1'b1; cu.Rout = 1'b1; cu.alu_op = alu_sel; cu.Zin = 1'b1; end
          C_IMM: begin cu.Cout = 1'b1; cu.alu_op = alu_sel; cu.Zin = 1'b1; end
          C_LDI, C_LD, C_ST: begin cu.Cout = 1'b1; cu.Zin = 1'b1; end
          C_BRX: begin cu.PCout = 1'b1; cu.Yin = 1'b1; end
          default: last = 1'b1;
        endcase
      end
      S_T5: begin
        state_next = S_T6;
        case (iclass)
          C_REG, C_IMM, C_LDI: begin
            cu.Zlowout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; last = 1'b1;
          end
          C_LD, C_ST: begin cu.Zlowout = 1'b1; cu.MARin = 1'b1; end
          C_BRX:      begin cu.Cout = 1'b1; cu.Zin = 1'b1; end
          default:    last = 1'b1;
        endcase
      end
      S_T6: begin
        case (iclass)
          C_LD: begin
            cu.Read = 1'b1; cu.MDRin = 1'b1;
            if (cu.mem_ready) state_next = S_T7;
          end
          C_ST: begin
            cu.Gra = 1'b1; cu.Rout = 1'b1; cu.MDRin = 1'b1;
            state_next = S_T7;
          end
          C_BRX: begin
            cu.Zlowout = cu.CON_FF; cu.PCin = cu.CON_FF; last = 1'b1;
          end
          default: last = 1'b1;
        endcase
      end
      S_T7: begin
        case (iclass)
          C_LD:    begin cu.MDRout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; last = 1'b1; end
          C_ST:    begin cu.Write = 1'b1; last = cu.mem_ready; end
          default: last = 1'b1;
        endcase
      end
      S_PAUSE: begin
        cu.Run = 1'b0;
        if (!cu.stop) state_next = S_T0;
      end
      S_HALT: begin
        cu.Run = 1'b0;
      end
      default: begin
        cu.Run     = 1'b0;
        state_next = S_RESET;
      end
    endcase

    if (last) state_next = cu.stop ? S_PAUSE : S_T0;
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle strobe vectors compared to hand-built masks.
module tb_control_unit;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  control_unit_if cu();
  control_unit dut (.clock(clock), .reset(reset), .cu(cu));

  localparam logic [24:0] PCOUT = 25'd1 << 24, MARIN = 25'd1 << 23, INCPC = 25'd1 << 22,
    ZIN = 25'd1 << 21, ZLOW = 25'd1 << 20, PCIN = 25'd1 << 19, READ = 25'd1 << 18,
    WRITE = 25'd1 << 17, MDRIN = 25'd1 << 16, MDROUT = 25'd1 << 15, IRIN = 25'd1 << 14,
    YIN = 25'd1 << 13, CONIN = 25'd1 << 12, GRA = 25'd1 << 11, GRB = 25'd1 << 10,
    GRC = 25'd1 << 9, RIN = 25'd1 << 8, ROUT = 25'd1 << 7, BAOUT = 25'd1 << 6,
    COUT = 25'd1 << 5, RUN = 25'd1 << 4;
  localparam logic [24:0] F0 = PCOUT | MARIN | INCPC | ZIN | RUN;
  localparam logic [24:0] F1 = ZLOW | PCIN | READ | MDRIN | RUN;
  localparam logic [24:0] F2 = MDROUT | IRIN | RUN;

  int errors = 0;
  int checks = 0;

  function automatic logic [24:0] outs();
    return {cu.PCout, cu.MARin, cu.IncPC, cu.Zin, cu.Zlowout, cu.PCin, cu.Read, cu.Write,
            cu.MDRin, cu.MDRout, cu.IRin, cu.Yin, cu.CONin, cu.Gra, cu.Grb, cu.Grc,
            cu.Rin, cu.Rout, cu.BAout, cu.Cout, cu.Run, cu.alu_op};
  endfunction

  task automatic check(input string tag, input logic [24:0] got, input logic [24:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [24:0] exp);
    check(tag, outs(), exp);
    @(posedge clock); #1;
  endtask

  task automatic fetch(input string name);
    cyc({name, "_t0"}, F0);
    cyc({name, "_t1"}, F1);
    cyc({name, "_t2"}, F2);
  endtask

  task automatic restart(input string name);
    reset = 1'b1;
    @(posedge clock); #1;
    check({name, "_in_reset"}, outs(), 25'd0);
    reset = 1'b0;
    cyc({name, "_reset_state"}, 25'd0);
  endtask

  initial begin
    reset = 1'b1;
    cu.IR = 32'h0; cu.CON_FF = 1'b0; cu.mem_ready = 1'b1; cu.stop = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_hold", outs(), 25'd0);
    reset = 1'b0;
    cyc("reset_exit", 25'd0);

    cu.IR = 32'h18918000;
    fetch("add");
    cyc("add_t3", GRB | ROUT | YIN | RUN);
    cyc("add_t4", GRC | ROUT | ZIN | RUN);
    cyc("add_t5", ZLOW | GRA | RIN | RUN);

    cu.IR = 32'h20000000;
    fetch("sub");
    cyc("sub_t3", GRB | ROUT | YIN | RUN);
    cyc("sub_t4", GRC | ROUT | ZIN | RUN | 25'd1);
    cyc("sub_t5", ZLOW | GRA | RIN | RUN);

    cu.IR = 32'h68000000;
    fetch("ori");
    cyc("ori_t3", GRB | ROUT | YIN | RUN);
    cyc("ori_t4", COUT | ZIN | RUN | 25'd3);
    cyc("ori_t5", ZLOW | GRA | RIN | RUN);

    cu.IR = 32'h00800065;
    fetch("ld");
    cyc("ld_t3", GRB | BAOUT | YIN | RUN);
    cyc("ld_t4", COUT | ZIN | RUN);
    cyc("ld_t5", ZLOW | MARIN | RUN);
    cu.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("ld_t6_wait", READ | MDRIN | RUN);
    cu.mem_ready = 1'b1;
    cyc("ld_t6_done", READ | MDRIN | RUN);
    cyc("ld_t7", MDROUT | GRA | RIN | RUN);

    cu.IR = 32'h10000000;
    cyc("st_t0", F0);
    cu.mem_ready = 1'b0;
    cyc("st_t1_first", F1);
    cu.mem_ready = 1'b1;
    cyc("st_t1_held", F1 & ~PCIN);
    cyc("st_t2", F2);
    cyc("st_t3", GRB | BAOUT | YIN | RUN);
    cyc("st_t4", COUT | ZIN | RUN);
    cyc("st_t5", ZLOW | MARIN | RUN);
    cyc("st_t6", GRA | ROUT | MDRIN | RUN);
    cu.mem_ready = 1'b0;
    cyc("st_t7_wait", WRITE | RUN);
    cu.mem_ready = 1'b1;
    cyc("st_t7_done", WRITE | RUN);

    cu.IR = 32'h90000000;
    cu.CON_FF = 1'b0;
    fetch("brx0");
    cyc("brx0_t3", GRA | ROUT | CONIN | RUN);
    cyc("brx0_t4", PCOUT | YIN | RUN);
    cyc("brx0_t5", COUT | ZIN | RUN);
    cyc("brx0_t6", RUN);
    cu.CON_FF = 1'b1;
    fetch("brx1");
    cyc("brx1_t3", GRA | ROUT | CONIN | RUN);
    cyc("brx1_t4", PCOUT | YIN | RUN);
    cyc("brx1_t5", COUT | ZIN | RUN);
    cyc("brx1_t6", ZLOW | PCIN | RUN);
    cu.CON_FF = 1'b0;

    cu.IR = 32'hC8000000;
    fetch("nop");
    cyc("nop_t3", RUN);

    cu.IR = 32'h18918000;
    cu.stop = 1'b1;
    fetch("padd");
    cyc("padd_t3", GRB | ROUT | YIN | RUN);
    cyc("padd_t4", GRC | ROUT | ZIN | RUN);
    cyc("padd_t5", ZLOW | GRA | RIN | RUN);
    cyc("pause_1", 25'd0);
    cu.stop = 1'b0;
    cyc("pause_2", 25'd0);

    cu.IR = 32'h10000000;
    fetch("rst_st");
    cyc("rst_st_t3", GRB | BAOUT | YIN | RUN);
    check("rst_st_t4", outs(), COUT | ZIN | RUN);
    #2 reset = 1'b1;
    #1 check("async_reset", outs(), 25'd0);
    @(posedge clock); #1;
    check("reset_held", outs(), 25'd0);
    reset = 1'b0;
    cyc("reset_exit2", 25'd0);

    cu.IR = 32'hD0000000;
    fetch("halt");
    cyc("halt_t3", RUN);
    for (int i = 0; i < 20; i++) cyc("halt_idle", 25'd0);
    restart("halt_rst");
    check("restart_t0", outs(), F0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The interface SHALL be: one clock; reset is asynchronous and active-high.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-high; forces the RESET state.
REQ-004 IR  input  32  instruction register contents; opcode is IR[31:27].
REQ-005 CON_FF  input  1  branch condition flip-flop output.
REQ-006 mem_ready  input  1  memory read/write complete, sampled each cycle.
REQ-007 stop  input  1  request to pause at the next instruction boundary.
REQ-008 PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Write, MDRin, MDRout, IRin, Yin, CONin  output  1 each  datapath strobes.
REQ-009 Gra, Grb, Grc, Rin, Rout, BAout, Cout  output  1 each  register select/encode controls.
REQ-010 alu_op  output  4  ALU operation: 0 ADD, 1 SUB, 2 AND, 3 OR; 0 when unused.
REQ-011 Run  output  1  high while executing; low in RESET, PAUSE and HALT.

Function
REQ-012 The FSM states SHALL be RESET, T0..T7, PAUSE and HALT; all outputs are Moore (state plus IR), and any strobe not listed for a state is 0.
REQ-013 RESET SHALL go to T0 on the first clock after reset deasserts.
REQ-014 Fetch: T0 asserts PCout, MARin, IncPC, Zin; T1 asserts Zlowout, PCin, Read, MDRin; T2 asserts MDRout, IRin.
REQ-015 T1 SHALL hold, keeping its strobes but with PCin only in the first T1 cycle, while mem_ready=0.
REQ-016 Reg ALU (add 00011, sub 00100, and 01001, or 01010): T3 Grb, Rout, Yin; T4 Grc, Rout, alu_op, Zin; T5 Zlowout, Gra, Rin.
REQ-017 Imm ALU (addi 01011 ADD, andi 01100 AND, ori 01101 OR): T3 Grb, Rout, Yin; T4 Cout, alu_op, Zin; T5 Zlowout, Gra, Rin.
REQ-018 ldi (00001): T3 Grb, BAout, Yin; T4 Cout, ADD, Zin; T5 Zlowout, Gra, Rin.
REQ-019 ld (00000): T3 to T4 as for ldi; T5 Zlowout, MARin; T6 Read, MDRin, held while mem_ready=0; T7 MDRout, Gra, Rin.
REQ-020 st (00010): T3 to T5 as for ld; T6 Gra, Rout, MDRin (Read=0); T7 Write, held while mem_ready=0.
REQ-021 brx (10010): T3 Gra, Rout, CONin; T4 PCout, Yin; T5 Cout, ADD, Zin; T6 Zlowout and PCin only if CON_FF=1.
REQ-022 nop (11001) and every unlisted opcode SHALL spend one T3 cycle with no strobes.
REQ-023 halt (11010): T3 SHALL go to HALT, which stays until reset.
REQ-024 The last step of every instruction SHALL go to T0 if stop=0, otherwise to PAUSE.
REQ-025 PAUSE SHALL go to T0 on the first cycle with stop=0.
REQ-026 Instruction latency with mem_ready=1: reg/imm ALU, ldi 6 cycles; ld, st 8; brx 7; nop 4.
REQ-027 At most one of Gra/Grb/Grc, and at most one bus driver (PCout, Zlowout, MDRout, Rout, BAout, Cout), SHALL be high in any cycle.

Reset
REQ-028 Asserting reset in any state, including mid-instruction or during a memory hold, SHALL immediately force RESET with every output 0 and Run=0.
REQ-029 No output SHALL glitch high during or on exit from reset.

Verification
REQ-030 Reset pulse, then release with mem_ready=1 -> one RESET cycle, then T0 with PCout=MARin=IncPC=Zin=1 and Run=1.
REQ-031 IR=0x18918000 (add R1,R2,R3) -> T3 Grb+Rout+Yin, T4 Grc+Rout+Zin with alu_op=0, T5 Gra+Rin, then T0 (6 cycles total).
REQ-032 IR=0x00800065 (ld R1,0x65(R0)), mem_ready low for 3 cycles during T6 -> T6 held 4 cycles, then T7 MDRout+Gra+Rin.
REQ-033 brx with CON_FF=0 and then CON_FF=1 -> T6 shows PCin=0 and PCin=1 respectively; both return to T0.
REQ-034 IR=0xD0000000 (halt) -> HALT with Run=0 and all strobes 0 for 20 cycles; reset then restarts fetch.
REQ-035 stop=1 during an add, and reset asserted in T4 of a st -> PAUSE after T5 with T0 resuming when stop drops; outputs 0 at once on reset.
